// File: rtl/pipeline_ctrl_pkg.sv
// pipeline_ctrl_pkg: shared ARM pipeline stage record, defaults and stage-control helper
package pipeline_ctrl_pkg;

    localparam int DEF_DEPTH    = 4;
    localparam int DEF_DATA_W   = 32;
    localparam int DEF_REG_AW   = 4;
    localparam int DEF_MEM_STG  = 1;
    localparam int DEF_HAZ_STGS = 2;

    typedef enum logic [1:0] {
        STG_HOLD,
        STG_BUBBLE,
        STG_LOAD
    } stage_op_e;

    typedef struct packed {
        logic                  valid;
        logic                  wb_en;
        logic [DEF_REG_AW-1:0] dest;
        logic [DEF_DATA_W-1:0] payload;
    } stage_t;

    // Per-stage action: a memory stall freezes the front end and opens a gap behind
    // the memory stage; otherwise everything advances and stage 0 may take a bubble.
    function automatic stage_op_e stage_op(int k, int mem_stg, logic busy, logic bubble0);
        if (busy) begin
            if (k <= mem_stg) return STG_HOLD;
            if (k == mem_stg + 1) return STG_BUBBLE;
            return STG_LOAD;
        end
        if (k == 0 && bubble0) return STG_BUBBLE;
        return STG_LOAD;
    endfunction

endpackage

// File: rtl/pipeline_ctrl_pipe_stage_reg.sv
// pipe_stage_reg: one pipeline stage record with hold, bubble and load actions
module pipe_stage_reg
    import pipeline_ctrl_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int REG_AW = DEF_REG_AW
) (
    input  logic              clk,
    input  logic              rst,
    input  stage_op_e         op_i,
    input  logic              valid_i,
    input  logic              wb_en_i,
    input  logic [REG_AW-1:0] dest_i,
    input  logic [DATA_W-1:0] payload_i,
    output logic              valid_o,
    output logic              wb_en_o,
    output logic [REG_AW-1:0] dest_o,
    output logic [DATA_W-1:0] payload_o
);

    logic              valid_q, valid_d;
    logic              wb_en_q, wb_en_d;
    logic [REG_AW-1:0] dest_q, dest_d;
    logic [DATA_W-1:0] payload_q, payload_d;

    // Load takes the upstream record; a bubble only drops valid so the payload stays visible
    always_comb begin
        valid_d   = op_i == STG_LOAD ? valid_i : (op_i == STG_BUBBLE ? 1'b0 : valid_q);
        wb_en_d   = op_i == STG_LOAD ? wb_en_i : wb_en_q;
        dest_d    = op_i == STG_LOAD ? dest_i : dest_q;
        payload_d = op_i == STG_LOAD ? payload_i : payload_q;
    end

    // Stage record flops, cleared asynchronously so held contents never survive reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q   <= 1'b0;
            wb_en_q   <= 1'b0;
            dest_q    <= '0;
            payload_q <= '0;
        end else begin
            valid_q   <= valid_d;
            wb_en_q   <= wb_en_d;
            dest_q    <= dest_d;
            payload_q <= payload_d;
        end
    end

    assign valid_o   = valid_q;
    assign wb_en_o   = wb_en_q;
    assign dest_o    = dest_q;
    assign payload_o = payload_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: post-decode stage tracking with RAW hazard, flush and memory-stall control
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int DEPTH    = DEF_DEPTH,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int REG_AW   = DEF_REG_AW,
    parameter int MEM_STG  = DEF_MEM_STG,
    parameter int HAZ_STGS = DEF_HAZ_STGS
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic                    in_wb_en,
    input  logic                    in_two_src,
    input  logic [REG_AW-1:0]       in_dest,
    input  logic [REG_AW-1:0]       in_src1,
    input  logic [REG_AW-1:0]       in_src2,
    input  logic [DATA_W-1:0]       in_payload,
    input  logic                    branch_taken,
    input  logic                    mem_busy,
    output logic                    freeze,
    output logic                    flush,
    output logic                    hazard,
    output logic [DEPTH-1:0]        stage_valid,
    output logic [DEPTH*DATA_W-1:0] stage_payload,
    output logic                    wb_en,
    output logic [REG_AW-1:0]       wb_dest,
    output logic [15:0]             stall_cnt,
    output logic [15:0]             flush_cnt
);

    logic [DEPTH-1:0]  v, wbe;
    logic [REG_AW-1:0] dest [DEPTH];
    logic [DATA_W-1:0] pay [DEPTH];
    logic [15:0]       stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

    // RAW check against the leading stages; invalid stages never match
    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < HAZ_STGS; i++)
            hazard = hazard | (v[i] & wbe[i] & (dest[i] == in_src1 | (in_two_src & dest[i] == in_src2)));
        hazard = hazard & in_valid;
    end

    assign flush  = branch_taken & v[0] & ~mem_busy;
    assign freeze = rst & (mem_busy | (hazard & ~flush));

    for (genvar k = 0; k < DEPTH; k++) begin : g_stg
        logic              up_v, up_wb;
        logic [REG_AW-1:0] up_dest;
        logic [DATA_W-1:0] up_pay;
        if (k == 0) begin : g_head
            assign {up_v, up_wb, up_dest, up_pay} = {in_valid, in_wb_en, in_dest, in_payload};
        end else begin : g_tail
            assign {up_v, up_wb, up_dest, up_pay} = {v[k-1], wbe[k-1], dest[k-1], pay[k-1]};
        end
        pipe_stage_reg #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_stg (
            .clk       (clk),
            .rst       (rst),
            .op_i      (stage_op(k, MEM_STG, mem_busy, flush | hazard)),
            .valid_i   (up_v),
            .wb_en_i   (up_wb),
            .dest_i    (up_dest),
            .payload_i (up_pay),
            .valid_o   (v[k]),
            .wb_en_o   (wbe[k]),
            .dest_o    (dest[k]),
            .payload_o (pay[k])
        );
        assign stage_payload[k*DATA_W +: DATA_W] = pay[k];
    end

    // Saturating event counters: add one unless already all ones
    always_comb begin
        stall_cnt_d = stall_cnt_q + {15'd0, freeze & ~&stall_cnt_q};
        flush_cnt_d = flush_cnt_q + {15'd0, flush & ~&flush_cnt_q};
    end

    // Counter flops
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stage_valid = v;
    assign wb_en       = v[DEPTH-1] & wbe[DEPTH-1];
    assign wb_dest     = v[DEPTH-1] ? dest[DEPTH-1] : '0;
    assign stall_cnt   = stall_cnt_q;
    assign flush_cnt   = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: directed stimulus with a write-back scoreboard for pipeline_ctrl
module tb_pipeline_ctrl;

    logic        clk, rst;
    logic        in_valid, in_wb_en, in_two_src;
    logic [3:0]  in_dest, in_src1, in_src2;
    logic [31:0] in_payload;
    logic        branch_taken, mem_busy;
    logic        freeze, flush, hazard, wb_en;
    logic [3:0]  stage_valid, wb_dest;
    logic [127:0] stage_payload;
    logic [15:0] stall_cnt, flush_cnt;

    typedef struct {
        logic [3:0]  dest;
        logic [31:0] pay;
        int          cyc;
    } exp_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   c;

    pipeline_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_wb_en      (in_wb_en),
        .in_two_src    (in_two_src),
        .in_dest       (in_dest),
        .in_src1       (in_src1),
        .in_src2       (in_src2),
        .in_payload    (in_payload),
        .branch_taken  (branch_taken),
        .mem_busy      (mem_busy),
        .freeze        (freeze),
        .flush         (flush),
        .hazard        (hazard),
        .stage_valid   (stage_valid),
        .stage_payload (stage_payload),
        .wb_en         (wb_en),
        .wb_dest       (wb_dest),
        .stall_cnt     (stall_cnt),
        .flush_cnt     (flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in;
        in_valid = 0; in_wb_en = 0; in_two_src = 0;
        in_dest = 0; in_src1 = 0; in_src2 = 0; in_payload = 0;
        branch_taken = 0; mem_busy = 0;
    endtask

    task automatic issue(input logic [3:0] d, input logic [3:0] s1, input logic [3:0] s2,
                         input logic two, input logic wb, input logic [31:0] p);
        in_valid = 1; in_dest = d; in_src1 = s1; in_src2 = s2;
        in_two_src = two; in_wb_en = wb; in_payload = p;
    endtask

    task automatic expect_wb(input logic [3:0] d, input logic [31:0] p, input int at);
        exp_t e;
        e.dest = d; e.pay = p; e.cyc = at;
        sbq.push_back(e);
    endtask

    // Monitor: every write-back the DUT presents is matched against the scoreboard head
    always @(negedge clk) begin
        if (rst && wb_en) begin
            total++;
            if (sbq.size() == 0) begin
                bad++;
                $display("FAIL wb_unexpected: got dest %0h pay %0h at cycle %0d, want no write-back",
                         wb_dest, stage_payload[96 +: 32], cyc);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                if (wb_dest !== e.dest || stage_payload[96 +: 32] !== e.pay || cyc != e.cyc) begin
                    bad++;
                    $display("FAIL wb_match: got dest %0h pay %0h cycle %0d, want dest %0h pay %0h cycle %0d",
                             wb_dest, stage_payload[96 +: 32], cyc, e.dest, e.pay, e.cyc);
                end
            end
        end
    end

    initial begin
        rst = 0;
        idle_in();
        issue(4'h3, 4'h3, 4'h3, 1'b1, 1'b1, 32'hAA);
        mem_busy = 1;
        #12;
        chk("rst_valid", stage_valid, 0);
        chk("rst_freeze", freeze, 0);
        chk("rst_flush", flush, 0);
        chk("rst_hazard", hazard, 0);
        chk("rst_wb_en", wb_en, 0);
        chk("rst_stall_cnt", stall_cnt, 0);
        chk("rst_flush_cnt", flush_cnt, 0);
        tick;
        chk("rst_edge_valid", stage_valid, 0);
        idle_in();
        rst = 1;
        #1;
        chk("rel_freeze", freeze, 0);
        chk("rel_wb_en", wb_en, 0);
        tick;
        chk("rel_next_valid", stage_valid, 0);
        chk("rel_next_flush", flush, 0);

        // straight flow, no dependencies
        c = cyc;
        issue(4'h1, 4'h0, 4'h0, 1'b0, 1'b1, 32'h00); expect_wb(4'h1, 32'h00, c + 4); tick;
        issue(4'h2, 4'h0, 4'h0, 1'b0, 1'b1, 32'h04); expect_wb(4'h2, 32'h04, c + 5); tick;
        issue(4'h5, 4'h0, 4'h0, 1'b0, 1'b1, 32'h08); expect_wb(4'h5, 32'h08, c + 6); #1;
        chk("flow_no_hazard", hazard, 0);
        tick;
        idle_in();
        chk("flow_valid", stage_valid, 4'b0111);
        repeat (5) tick;
        chk("flow_stall_cnt", stall_cnt, 0);

        // RAW on src1: two-cycle stall while the producer sits in stages 0 and 1
        c = cyc;
        issue(4'h3, 4'h0, 4'h0, 1'b0, 1'b1, 32'h10); expect_wb(4'h3, 32'h10, c + 4); tick;
        issue(4'h6, 4'h3, 4'h0, 1'b0, 1'b1, 32'h14); #1;
        chk("raw_hazard_s0", hazard, 1);
        chk("raw_freeze_s0", freeze, 1);
        chk("raw_flush", flush, 0);
        tick;
        chk("raw_bubble", stage_valid, 4'b0010);
        chk("raw_hazard_s1", hazard, 1);
        chk("raw_freeze_s1", freeze, 1);
        tick;
        chk("raw_clear", hazard, 0);
        chk("raw_clear_freeze", freeze, 0);
        chk("raw_valid", stage_valid, 4'b0100);
        expect_wb(4'h6, 32'h14, cyc + 4);
        tick;
        idle_in();
        repeat (6) tick;
        chk("raw_stall_cnt", stall_cnt, 2);

        // src2 only counts with two_src; a stage without wb_en never matches
        c = cyc;
        issue(4'h7, 4'h0, 4'h0, 1'b0, 1'b1, 32'h20); expect_wb(4'h7, 32'h20, c + 4); tick;
        issue(4'h8, 4'h0, 4'h7, 1'b0, 1'b0, 32'h24); #1;
        chk("src2_gated", hazard, 0);
        tick;
        issue(4'h9, 4'h8, 4'h7, 1'b1, 1'b1, 32'h28); #1;
        chk("src2_hazard", hazard, 1);
        tick;
        chk("nowb_ignored", hazard, 0);
        expect_wb(4'h9, 32'h28, cyc + 4);
        tick;
        idle_in();
        repeat (7) tick;
        chk("src2_stall_cnt", stall_cnt, 3);

        // branch: flush kills the instruction entering stage 0
        c = cyc;
        issue(4'h9, 4'h0, 4'h0, 1'b0, 1'b1, 32'h30); expect_wb(4'h9, 32'h30, c + 4); tick;
        issue(4'hA, 4'h0, 4'h0, 1'b0, 1'b1, 32'h34); branch_taken = 1; #1;
        chk("br_flush", flush, 1);
        chk("br_freeze", freeze, 0);
        tick;
        idle_in();
        branch_taken = 1; #1;
        chk("br_bubble", stage_valid, 4'b0010);
        chk("br_no_v0_flush", flush, 0);
        chk("br_flush_cnt", flush_cnt, 1);
        tick;
        idle_in();
        repeat (6) tick;
        chk("br_flush_cnt_hold", flush_cnt, 1);

        // memory stall for three cycles with a simultaneous branch
        c = cyc;
        issue(4'hB, 4'h0, 4'h0, 1'b0, 1'b1, 32'h40); expect_wb(4'hB, 32'h40, c + 7); tick;
        issue(4'hC, 4'h0, 4'h0, 1'b0, 1'b1, 32'h44); expect_wb(4'hC, 32'h44, c + 8); tick;
        issue(4'hD, 4'h0, 4'h0, 1'b0, 1'b1, 32'h48);
        mem_busy = 1; branch_taken = 1; #1;
        chk("mb_flush", flush, 0);
        chk("mb_freeze", freeze, 1);
        repeat (3) begin
            tick;
            chk("mb_hold_front", stage_valid[1:0], 2'b11);
            chk("mb_gap", stage_valid[2], 0);
            chk("mb_hold_pay1", stage_payload[32 +: 32], 32'h40);
        end
        idle_in();
        repeat (6) tick;
        chk("mb_stall_cnt", stall_cnt, 6);
        chk("mb_flush_cnt", flush_cnt, 1);

        // async reset while an instruction is held by a memory stall
        issue(4'hD, 4'h0, 4'h0, 1'b0, 1'b1, 32'h50); tick;
        idle_in();
        mem_busy = 1;
        tick; tick;
        chk("ar_held", stage_valid, 4'b0001);
        #2;
        rst = 0;
        #1;
        chk("ar_valid", stage_valid, 0);
        chk("ar_freeze", freeze, 0);
        chk("ar_flush", flush, 0);
        chk("ar_wb_en", wb_en, 0);
        chk("ar_stall_cnt", stall_cnt, 0);
        chk("ar_flush_cnt", flush_cnt, 0);
        tick;
        idle_in();
        rst = 1;
        tick; tick;
        chk("ar_after_valid", stage_valid, 0);
        chk("ar_after_stall", stall_cnt, 0);

        // saturation of the stall counter
        mem_busy = 1;
        repeat (65534) tick;
        chk("sat_fffe", stall_cnt, 16'hFFFE);
        tick;
        chk("sat_ffff", stall_cnt, 16'hFFFF);
        repeat (5) tick;
        chk("sat_stays", stall_cnt, 16'hFFFF);
        chk("sat_flush_cnt", flush_cnt, 0);
        idle_in();
        tick; tick;

        chk("sb_drained", sbq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
